k2red_mul_front: RTL and testbench

//  Operand front-end of the K2-RED modular multiplier datapath. It accepts operand pairs (A,B) on a

---
 rtl/k2red_mul_front.sv | 164 ++++++++++++++++
 tb/tb_k2red_mul_front.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/k2red_mul_front.sv
// k2red_mul_front
//   Operand front-end of the K2-RED modular multiplier. Accepts (A,B,tag) on a
//   valid/ready interface, forms the full 2*LOGQ-bit product through a
//   fixed-latency, non-stalling pipeline (LAT = FF_IN + MUL_STAGES) and hands it
//   to the K2-RED reduction stage. Because the reduction stage cannot stall,
//   issue is gated by a credit counter that the downstream result buffer
//   replenishes.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid/in_ready     operand handshake; in_ready depends only on credits
//   in_a, in_b, in_tag    operands and sideband tag
//   c_valid, c_out, c_tag product to K2-RED, single-cycle qualifier, held when idle
//   cred_ret              one result-buffer slot freed this cycle
//   credits               current credit count
//   cred_err              sticky: credit returned while already full
module k2red_mul_front #(
    parameter int LOGQ       = 32,
    parameter int TAGW       = 4,
    parameter int FF_IN      = 1,
    parameter int MUL_STAGES = 2,
    parameter int CREDITS    = 8,
    localparam int LOGC      = 2 * LOGQ,
    localparam int CW        = $clog2(CREDITS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [LOGQ-1:0] in_a,
    input  logic [LOGQ-1:0] in_b,
    input  logic [TAGW-1:0] in_tag,
    output logic            c_valid,
    output logic [LOGC-1:0] c_out,
    output logic [TAGW-1:0] c_tag,
    input  logic            cred_ret,
    output logic [CW-1:0]   credits,
    output logic            cred_err
);

    logic            w_accept;
    logic            w_mv;
    logic [LOGQ-1:0] w_ma;
    logic [LOGQ-1:0] w_mb;
    logic [TAGW-1:0] w_mt;
    logic [LOGC-1:0] w_prod;

    logic [CW-1:0]   r_cred;
    logic [CW-1:0]   w_cred_nxt;
    logic            r_err;
    logic            w_err_set;

    // in_ready is a pure function of the counter, so a returned credit at zero
    // only opens the interface on the following cycle.
    assign in_ready = (r_cred != '0);
    assign w_accept = in_valid & in_ready;

    // ---------------------------------------------------------------- input stage
    generate
        if (FF_IN != 0) begin : g_ff_in
            logic            r_in_v;
            logic [LOGQ-1:0] r_a;
            logic [LOGQ-1:0] r_b;
            logic [TAGW-1:0] r_tag;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_in_v <= 1'b0;
                end else begin
                    r_in_v <= w_accept;
                end
            end

            // Operand registers need no reset; they are qualified by r_in_v.
            always_ff @(posedge clk) begin
                if (w_accept) begin
                    r_a   <= in_a;
                    r_b   <= in_b;
                    r_tag <= in_tag;
                end
            end

            assign w_mv = r_in_v;
            assign w_ma = r_a;
            assign w_mb = r_b;
            assign w_mt = r_tag;
        end else begin : g_no_ff
            assign w_mv = w_accept;
            assign w_ma = in_a;
            assign w_mb = in_b;
            assign w_mt = in_tag;
        end
    endgenerate

    // Operands are widened before the multiply so no high bits are lost.
    assign w_prod = LOGC'(w_ma) * LOGC'(w_mb);

    // ---------------------------------------------------------- multiplier pipe
    logic [MUL_STAGES-1:0] r_v;
    logic [LOGC-1:0]       r_p [MUL_STAGES];
    logic [TAGW-1:0]       r_t [MUL_STAGES];

    // Valid bits shift every cycle; data only moves with a valid so the last
    // stage (c_out/c_tag) holds its value between results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
            for (int i = 0; i < MUL_STAGES; i++) begin
                r_p[i] <= '0;
                r_t[i] <= '0;
            end
        end else begin
            r_v[0] <= w_mv;
            if (w_mv) begin
                r_p[0] <= w_prod;
                r_t[0] <= w_mt;
            end
            for (int i = 1; i < MUL_STAGES; i++) begin
                r_v[i] <= r_v[i-1];
                if (r_v[i-1]) begin
                    r_p[i] <= r_p[i-1];
                    r_t[i] <= r_t[i-1];
                end
            end
        end
    end

    assign c_valid = r_v[MUL_STAGES-1];
    assign c_out   = r_p[MUL_STAGES-1];
    assign c_tag   = r_t[MUL_STAGES-1];

    // ------------------------------------------------------------ credit counter
    // Simultaneous accept and return cancel. A return while full saturates and
    // flags cred_err; underflow is impossible since accept needs a credit.
    always_comb begin
        w_cred_nxt = r_cred;
        w_err_set  = 1'b0;
        if (w_accept && !cred_ret) begin
            w_cred_nxt = r_cred - CW'(1);
        end else if (!w_accept && cred_ret) begin
            if (r_cred == CW'(CREDITS)) begin
                w_err_set = 1'b1;
            end else begin
                w_cred_nxt = r_cred + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cred <= CW'(CREDITS);
            r_err  <= 1'b0;
        end else begin
            r_cred <= w_cred_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign credits  = r_cred;
    assign cred_err = r_err;

endmodule

// File: tb/tb_k2red_mul_front.sv
// tb_k2red_mul_front
//   Directed bench for k2red_mul_front with default parameters (LOGQ=32,
//   TAGW=4, FF_IN=1, MUL_STAGES=2, CREDITS=8, so LAT=3). A negedge monitor keeps
//   an expected-result queue and a credit model; the main sequence drives
//   hand-computed vectors and the credit corner cases.
module tb_k2red_mul_front;

    localparam int LAT = 3;
    localparam int NCR = 8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_tag;
    logic        c_valid;
    logic [63:0] c_out;
    logic [3:0]  c_tag;
    logic        cred_ret;
    logic [3:0]  credits;
    logic        cred_err;

    k2red_mul_front dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_tag   (in_tag),
        .c_valid  (c_valid),
        .c_out    (c_out),
        .c_tag    (c_tag),
        .cred_ret (cred_ret),
        .credits  (credits),
        .cred_err (cred_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------ monitor
    typedef struct {
        logic [63:0] p;
        logic [3:0]  t;
        int          c;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   m_cred = NCR;
    bit   m_err  = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        bit   acc;
        cyc++;
        if (rst) begin
            q.delete();
            m_cred = NCR;
            m_err  = 1'b0;
        end else begin
            chk("mon_credits", 64'(credits), 64'(m_cred));
            chk("mon_in_ready", 64'(in_ready), 64'(m_cred != 0));
            chk("mon_cred_err", 64'(cred_err), 64'(m_err));
            if (c_valid) begin
                if (q.size() == 0) begin
                    chk("mon_spurious_c_valid", 64'(c_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("mon_c_out", c_out, e.p);
                    chk("mon_c_tag", 64'(c_tag), 64'(e.t));
                    chk("mon_latency", 64'(cyc), 64'(e.c));
                end
            end
            acc = in_valid && (m_cred != 0);
            if (acc) begin
                e.p = {32'd0, in_a} * {32'd0, in_b};
                e.t = in_tag;
                e.c = cyc + LAT;
                q.push_back(e);
            end
            if (acc && !cred_ret) begin
                m_cred--;
            end else if (!acc && cred_ret) begin
                if (m_cred == NCR) m_err = 1'b1;
                else m_cred++;
            end
        end
    end

    // --------------------------------------------------------------- sequences
    task automatic send_vec(input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] tg, input logic [63:0] exp, input string nm);
        int n;
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = tg;
        step();
        in_valid = 1'b0;
        n = 1;
        while (!c_valid && n < 10) begin
            step();
            n++;
        end
        chk({nm, "_lat"}, 64'(n), 64'(LAT));
        chk({nm, "_c_out"}, c_out, exp);
        chk({nm, "_c_tag"}, 64'(c_tag), 64'(tg));
        cred_ret = 1'b1;
        step();
        cred_ret = 1'b0;
        chk({nm, "_c_valid_drop"}, 64'(c_valid), 64'd0);
        chk({nm, "_c_out_hold"}, c_out, exp);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; cred_ret = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        chk("rst_c_valid", 64'(c_valid), 64'd0);
        chk("rst_c_out", c_out, 64'd0);
        chk("rst_c_tag", 64'(c_tag), 64'd0);
        chk("rst_credits", 64'(credits), 64'd8);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_cred_err", 64'(cred_err), 64'd0);
        step();

        // single products
        send_vec(32'h1234_5678, 32'h9ABC_DEF0, 4'h5, 64'h0B00_EA4E_242D_2080, "v1");
        send_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hA, 64'hFFFF_FFFE_0000_0001, "vmax");
        send_vec(32'h0000_0000, 32'hDEAD_BEEF, 4'h3, 64'h0, "vzero");
        send_vec(32'h0001_0000, 32'h0001_0000, 4'hC, 64'h0000_0001_0000_0000, "vcarry");

        // back-to-back until credits run out; 9th request must be refused
        chk("b2b_start_credits", 64'(credits), 64'd8);
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_a     = 32'(i + 1) * 32'h0100_0001;
            in_b     = 32'(i + 3);
            in_tag   = 4'(i);
            step();
            if (i < 8) chk("b2b_credits", 64'(credits), 64'(7 - i));
        end
        in_valid = 1'b0;
        chk("b2b_credits_zero", 64'(credits), 64'd0);
        chk("b2b_in_ready_low", 64'(in_ready), 64'd0);
        repeat (6) step();
        chk("b2b_drained", 64'(q.size()), 64'd0);

        // return at zero: in_ready rises only after the edge
        cred_ret = 1'b1;
        #1;
        chk("ret0_in_ready_same_cycle", 64'(in_ready), 64'd0);
        step();
        cred_ret = 1'b0;
        chk("ret0_credits", 64'(credits), 64'd1);
        chk("ret0_in_ready", 64'(in_ready), 64'd1);
        cred_ret = 1'b1;
        repeat (2) step();
        cred_ret = 1'b0;
        chk("credits_3", 64'(credits), 64'd3);

        // accept and return in the same cycle cancel
        in_valid = 1'b1; in_a = 32'd7; in_b = 32'd6; in_tag = 4'hE; cred_ret = 1'b1;
        step();
        in_valid = 1'b0; cred_ret = 1'b0;
        chk("acc_ret_credits", 64'(credits), 64'd3);

        cred_ret = 1'b1;
        repeat (5) step();
        cred_ret = 1'b0;
        chk("refill_credits", 64'(credits), 64'd8);
        chk("refill_cred_err", 64'(cred_err), 64'd0);

        // over-return while full: saturate and set sticky error
        cred_ret = 1'b1;
        step();
        cred_ret = 1'b0;
        chk("over_credits", 64'(credits), 64'd8);
        chk("over_cred_err", 64'(cred_err), 64'd1);
        repeat (3) step();
        chk("over_cred_err_sticky", 64'(cred_err), 64'd1);

        // async reset with two products in flight
        in_valid = 1'b1; in_a = 32'd11; in_b = 32'd13; in_tag = 4'h1;
        step();
        in_a = 32'd17; in_b = 32'd19; in_tag = 4'h2;
        step();
        in_valid = 1'b0;
        step();
        chk("inflight_c_valid", 64'(c_valid), 64'd1);
        chk("inflight_credits", 64'(credits), 64'd6);
        #2 rst = 1'b1;
        #1;
        chk("arst_c_valid", 64'(c_valid), 64'd0);
        chk("arst_c_out", c_out, 64'd0);
        chk("arst_credits", 64'(credits), 64'd8);
        chk("arst_cred_err", 64'(cred_err), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_no_c_valid", 64'(c_valid), 64'd0);
        end
        chk("post_rst_credits", 64'(credits), 64'd8);
        chk("post_rst_cred_err", 64'(cred_err), 64'd0);

        // normal operation resumes after reset
        send_vec(32'h0000_FFFF, 32'h0001_0001, 4'h9, 64'h0000_0000_FFFF_FFFF, "vpost");
        chk("final_queue_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
